// File: rtl/servo_pwm_multi.sv
// -----------------------------------------------------------------------------
// servo_pwm_multi
//
// Multi-channel servo PWM generator. All channels share one period counter.
// Each channel holds a double-buffered pulse width:
//   shadow[c]  written by the host, clamped to [MIN_PULSE, MAX_PULSE]
//   active[c]  width used for the current period
// active[] is reloaded from shadow[] on the last cycle of every period. While
// disabled, active[] is reloaded on every cycle. This means the first period
// after enable already uses the newest written value.
//
// Optional feature (macro SERVO_SLEW_EN):
//   When defined, each reload moves active[c] toward shadow[c] by at most
//   SLEW_STEP clocks. When undefined, active[c] takes shadow[c] directly and
//   SLEW_STEP has no effect.
//
// Host write handshake: Wr_i is a one-cycle strobe with no backpressure.
// A write is accepted on every clock edge where Wr_i is high. The status
// pulses Clamp_o and Err_o report that write one cycle later.
//
// Ports:
//   Clk_i    in   1         system clock
//   Reset_i  in   1         asynchronous active-low reset
//   En_i     in   1         global run enable (low: counter held at 0, outputs low)
//   Wr_i     in   1         write strobe
//   Ch_i     in   CH_W      target channel of the write
//   Pulse_i  in   CNT_W     requested high time in clocks
//   Pwm_o    out  CHANNELS  registered servo outputs
//   Frame_o  out  1         strobe in the first output cycle of each period
//   Clamp_o  out  1         the previous-cycle write was clamped
//   Err_o    out  1         the previous-cycle write targeted a missing channel
// -----------------------------------------------------------------------------
module servo_pwm_multi #(
    parameter int CHANNELS      = 4,
    parameter int PERIOD_CYCLES = 1000000,
    parameter int MIN_PULSE     = 25000,
    parameter int MAX_PULSE     = 125000,
    parameter int CNT_W         = 20,
    parameter int CH_W          = 2,
    parameter int SLEW_STEP     = 5000
) (
    input  logic                Clk_i,
    input  logic                Reset_i,
    input  logic                En_i,
    input  logic                Wr_i,
    input  logic [CH_W-1:0]     Ch_i,
    input  logic [CNT_W-1:0]    Pulse_i,
    output logic [CHANNELS-1:0] Pwm_o,
    output logic                Frame_o,
    output logic                Clamp_o,
    output logic                Err_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_P    = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] MID_P    = CNT_W'((MIN_PULSE + MAX_PULSE) / 2);
    // One extra bit so that CHANNELS = 2**CH_W is still representable.
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);

    // Reject parameter sets that the datapath cannot honour.
    if (CHANNELS < 1 || CHANNELS > 16 || MIN_PULSE > MAX_PULSE ||
        MAX_PULSE >= PERIOD_CYCLES || SLEW_STEP < 1) begin : g_bad_params
        $error("servo_pwm_multi: invalid parameter combination");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow      [CHANNELS];
    logic [CNT_W-1:0] active      [CHANNELS];

    // ------------------------------------------------------------------
    // Write decode and clamp
    // ------------------------------------------------------------------
    logic             ch_ok;
    logic             too_low;
    logic             too_high;
    logic [CNT_W-1:0] pulse_clamped;
    logic             load;

    always_comb begin
        ch_ok         = ({1'b0, Ch_i} < CH_LIMIT);
        too_low       = (Pulse_i < MIN_P);
        too_high      = (Pulse_i > MAX_P);
        pulse_clamped = Pulse_i;
        if (too_low) begin
            pulse_clamped = MIN_P;
        end else if (too_high) begin
            pulse_clamped = MAX_P;
        end
        // Reload on the last cycle of a period, or on every cycle while idle.
        load = En_i ? (cnt == LAST_CNT) : 1'b1;
    end

    // ------------------------------------------------------------------
    // Next active width per channel
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] next_active [CHANNELS];

`ifdef SERVO_SLEW_EN
    localparam logic [CNT_W-1:0] STEP = CNT_W'(SLEW_STEP);

    // Both values lie inside [MIN_P, MAX_P], so active +/- STEP only applies
    // when the gap exceeds STEP. The result therefore stays in range and
    // cannot wrap.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            next_active[c] = shadow[c];
            if (shadow[c] > active[c]) begin
                if ((shadow[c] - active[c]) > STEP) begin
                    next_active[c] = active[c] + STEP;
                end
            end else begin
                if ((active[c] - shadow[c]) > STEP) begin
                    next_active[c] = active[c] - STEP;
                end
            end
        end
    end
`else
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            next_active[c] = shadow[c];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            cnt <= '0;
        end else if (!En_i) begin
            cnt <= '0;
        end else if (cnt == LAST_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Shadow and active width registers
    // A load in the same cycle as a write sees the pre-write shadow. This is
    // because both registers update on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                shadow[c] <= MID_P;
                active[c] <= MID_P;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (Wr_i && ch_ok && (Ch_i == CH_W'(c))) begin
                    shadow[c] <= pulse_clamped;
                end
                if (load) begin
                    active[c] <= next_active[c];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] pwm_next;

    always_comb begin
        pwm_next = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pwm_next[c] = En_i && (cnt < active[c]);
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            Pwm_o   <= '0;
            Frame_o <= 1'b0;
            Clamp_o <= 1'b0;
            Err_o   <= 1'b0;
        end else begin
            Pwm_o   <= pwm_next;
            Frame_o <= En_i && (cnt == '0);
            Clamp_o <= Wr_i && ch_ok && (too_low || too_high);
            Err_o   <= Wr_i && !ch_ok;
        end
    end

endmodule

// File: doc/servo_pwm_multi.md
# servo_pwm_multi

Parametrised multi-channel servo PWM generator; the next generation of the single-channel MG995 PWM top, which offered only three fixed angles via a select input. Each channel has a programmable pulse width, clamped to a safe servo range. The width is double-buffered so changes only take effect at a period boundary. All channels share one period counter with a frame strobe. The block sits between the control logic (UART or register host) and the servo output pins.

## Interface
Parameters:
- CHANNELS, 4, number of servo outputs (1..16)
- PERIOD_CYCLES, 1000000, PWM period in clocks (20 ms at 50 MHz)
- MIN_PULSE, 25000, minimum high time in clocks (0.5 ms)
- MAX_PULSE, 125000, maximum high time in clocks (2.5 ms)
- CNT_W, 20, counter/pulse width; must hold PERIOD_CYCLES-1
- CH_W, 2, channel index width, max(1, clog2(CHANNELS))
- SLEW_STEP, 5000, max change of active width per period (only with SERVO_SLEW_EN)

Ports:
- Clk_i  in  1  system clock
- Reset_i  in  1  asynchronous, active-low reset
- En_i  in  1  global run enable
- Wr_i  in  1  write strobe, one-cycle, no backpressure
- Ch_i  in  CH_W  target channel for write
- Pulse_i  in  CNT_W  requested high time in clocks
- Pwm_o  out  CHANNELS  registered servo outputs
- Frame_o  out  1  one-cycle strobe, high in the first cycle of each period
- Clamp_o  out  1  one-cycle pulse: last accepted write was clamped
- Err_o  out  1  one-cycle pulse: write to channel index >= CHANNELS, ignored

## Operation
- Reset (Reset_i=0, async): the period counter is 0. Every shadow[c] and active[c] is MID = (MIN_PULSE+MAX_PULSE)/2, which is the neutral position, 75000 by default. Pwm_o, Frame_o, Clamp_o and Err_o are all 0.
- Period counter cnt:
  - counts 0..PERIOD_CYCLES-1 while En_i=1, then wraps to 0;
  - is held at 0 while En_i=0.
- Write (Wr_i=1):
  - When Ch_i < CHANNELS, shadow[Ch_i] gets the value clamp(Pulse_i, MIN_PULSE, MAX_PULSE).
  - Clamp_o pulses the next cycle if Pulse_i < MIN_PULSE or Pulse_i > MAX_PULSE.
  - When Ch_i >= CHANNELS, shadow is unchanged, Err_o pulses the next cycle and Clamp_o stays 0.
- Load: active[c] is updated from shadow[c] in two situations:
  - on the cycle where cnt == PERIOD_CYCLES-1 with En_i=1;
  - on every cycle while En_i=0, so the first period after enable uses the latest value.
- Write and load in the same cycle: the load takes the pre-write shadow value. The new value applies from the following period.
- Outputs, registered:
  - Pwm_o[c] <= En_i && (cnt < active[c]);
  - Frame_o <= En_i && (cnt == 0).
- Deasserting En_i mid-period: the counter returns to 0 and Pwm_o goes low on the next edge. This truncated pulse is accepted.
- Asserting Reset_i mid-operation: outputs and registers return to their reset values immediately, without waiting for a clock edge. Any pending shadow values are lost.

## Timing
- Write to output:
  - minimum latency is one period boundary;
  - maximum latency is PERIOD_CYCLES+1 clocks.
- Rising edges of Frame_o and of every Pwm_o[c] occur on the same clock edge, one clock after cnt==0.
- Each Pwm_o[c] is high for exactly active[c] clocks per period. The period is exactly PERIOD_CYCLES clocks.
- From En_i 0→1 to the first Frame_o and Pwm_o rising edge: 1 clock.
- Clamp_o and Err_o: 1-cycle latency after the Wr_i cycle.
- Back-to-back writes are accepted every cycle. The last write to a channel before the load cycle wins.
- Comparison is unsigned, CNT_W bits. MIN_PULSE <= MAX_PULSE < PERIOD_CYCLES is a parameter precondition.

## Configuration
- SERVO_SLEW_EN defined: at each load, active[c] moves toward shadow[c] by at most SLEW_STEP.
  - If |shadow-active| <= SLEW_STEP, active becomes shadow.
  - Otherwise active becomes active ± SLEW_STEP.
  - The same rule applies while En_i=0, once per clock.
- SERVO_SLEW_EN undefined: active[c] loads shadow[c] directly at each load. The SLEW_STEP parameter is ignored.

## Test plan
- Reset release, then En_i=1, no writes → every Pwm_o high for 75000 clocks. Frame_o spacing is 1000000 clocks.
- Write ch0=25000 and ch3=125000 mid-period → the current period is unchanged. The next period shows 25000 and 125000 high clocks; ch1 and ch2 stay at 75000.
- Write Pulse_i=10 to ch1, then 200000 to ch2 → Clamp_o pulses twice. Widths are 25000 and 125000.
- Write on the cycle where cnt==PERIOD_CYCLES-1 → the old width holds for one more period, then the new width appears.
- With CHANNELS=3, write Ch_i=3 → Err_o pulses. No output changes. Assert Reset_i low mid-pulse → Pwm_o is 0 immediately and all widths return to 75000.
- With SERVO_SLEW_EN, step ch0 from 75000 to 125000 → successive periods show 80000, 85000, … , 125000 (10 periods).
